// File: rtl/unsig_narrow.sv
// Unsigned width down-converter: one DATA_WIDTH word in, LS-first OUTPUT_WIDTH slices out.
// Latency: slice 0 appears the cycle after the word is accepted; one slice per cycle after that.
// Backpressure: out_ready low freezes the current slice; a new word is taken only while idle or on the final slice.
// Optional build macro UNSIG_NARROW_ZSKIP_EN: stop after the highest nonzero slice (zero word -> one slice).
module unsig_narrow #(
   parameter int DATA_WIDTH   = 32,
   parameter int OUTPUT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   din,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUTPUT_WIDTH-1:0] dout,
   output logic                    out_last,
   output logic                    busy
);

   localparam int N  = DATA_WIDTH / OUTPUT_WIDTH;
   localparam int IW = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [DATA_WIDTH-1:0]   sr;
   logic [IW-1:0]           idx;
   logic [IW-1:0]           lidx;
   logic [IW-1:0]           lidx_new;
   logic                    in_acc;
   logic                    out_acc;

   // Final slice index for the word currently presented on din
   always_comb begin
`ifdef UNSIG_NARROW_ZSKIP_EN
      lidx_new = '0;
      for (int i = 1; i < N; i++) begin
         if (din[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] != '0) begin
            lidx_new = IW'(i);
         end
      end
`else
      lidx_new = IW'(N - 1);
`endif
   end

   // Handshake outputs, all derived from held state except in_ready's out_ready path
   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      dout      = '0;
      busy      = 1'b0;
      if (state == SEND) begin
         out_valid = 1'b1;
         out_last  = (idx == lidx);
         dout      = sr[OUTPUT_WIDTH-1:0];
         busy      = 1'b1;
      end
      out_acc  = out_valid && out_ready;
      in_ready = (state == IDLE) || (out_acc && out_last);
      in_acc   = in_valid && in_ready;
   end

   // Next state: the completing slice can hand straight over to the next word
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (out_acc && out_last) begin
               state_nxt = in_valid ? SEND : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, shift register and slice counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         idx   <= '0;
         lidx  <= '0;
      end else begin
         state <= state_nxt;
         if (in_acc) begin
            sr   <= din;
            idx  <= '0;
            lidx <= lidx_new;
         end else if (out_acc && !out_last) begin
            sr  <= sr >> OUTPUT_WIDTH;
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: doc/unsig_narrow.md
# unsig_narrow

Unsigned width down-converter: the inverse of the pipeline's unsigned bit extender. It accepts one DATA_WIDTH word through a valid/ready handshake and emits it as a sequence of OUTPUT_WIDTH slices, least-significant slice first, through a second valid/ready handshake. It sits between wide datapath producers (register file, ALU results) and narrow consumers such as byte/halfword store paths and debug/trace ports. Optionally, it drops the upper all-zero slices that unsigned extension would restore.

## Interface
- DATA_WIDTH, 32, input word width; must be an integer multiple of OUTPUT_WIDTH.
- OUTPUT_WIDTH, 8, slice width; N = DATA_WIDTH/OUTPUT_WIDTH, N ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  din holds a word to transfer.
- in_ready  output  1  block can accept a word this cycle.
- din  input  DATA_WIDTH  raw wide word.
- out_valid  output  1  dout holds a valid slice.
- out_ready  input  1  consumer accepts dout this cycle.
- dout  output  OUTPUT_WIDTH  current slice.
- out_last  output  1  current slice is the final slice of its word.
- busy  output  1  a word is held (state SEND).

## Operation
- States:
  - IDLE: empty.
  - SEND: word held in shift register `sr`; slice index `idx`; final index `lidx`.
- Input transfer: when in_valid && in_ready at a rising edge:
  - sr ← din; idx ← 0; lidx computed from din; state ← SEND.
- Output transfer: when out_valid && out_ready at a rising edge:
  - If idx == lidx, the word is complete.
  - Otherwise sr shifts right by OUTPUT_WIDTH with zero fill, and idx increments.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last).
  - Back-to-back words therefore have no bubble.
  - On the completing edge, if in_valid is high the new word loads and the state stays SEND; otherwise state ← IDLE.
- Outputs in SEND: dout = sr[OUTPUT_WIDTH-1:0], out_valid = 1, out_last = (idx == lidx).
- Outputs in IDLE: out_valid = 0, out_last = 0, dout = 0.
- in_valid while in SEND and not completing: not accepted. The producer must hold din stable until in_ready.
- out_ready low: dout, out_last and idx hold. No slice is lost or repeated.
- No arithmetic beyond the idx increment. idx width is clog2(N); it never wraps because idx ≤ lidx ≤ N-1.

## Timing
- Reset values:
  - state IDLE, sr 0, idx 0, lidx 0.
  - out_valid 0, out_last 0, dout 0, busy 0, in_ready 1.
- Latency: word accepted at edge k gives slice 0 on dout from the cycle after edge k.
- Throughput: one slice per cycle when out_ready is held high. A word takes lidx+1 cycles.
- in_ready depends combinationally on out_ready. out_valid, dout and out_last are purely registered-state outputs.
- Reset asserted mid-word: the word is discarded immediately (asynchronous). After rst deasserts, the first accepted word starts at slice 0.

## Configuration
- UNSIG_NARROW_ZSKIP_EN undefined:
  - lidx = N-1 always; every word emits exactly N slices.
- UNSIG_NARROW_ZSKIP_EN defined:
  - lidx = index of the highest nonzero slice of din; a word equal to 0 gives lidx 0 and emits one slice of 0.
  - Concatenating the emitted slices and zero-extending them to DATA_WIDTH reproduces din exactly.
  - lidx is computed combinationally from din at accept time.

## Test plan
- Reset then idle: rst pulse mid-cycle → out_valid 0, dout 0, in_ready 1 immediately. With in_valid low, the outputs stay idle.
- Single word, out_ready=1, din=0x12345678 (no macro) → dout 0x78, 0x34… wait for order: dout 0x78, 0x56, 0x34, 0x12 on 4 consecutive cycles, out_last only on 0x12, then out_valid 0.
- Backpressure: same word, out_ready low for 3 cycles at slice 1 → dout holds 0x56 with out_valid high for 3 cycles, then 0x34, 0x12. Total cycles = 4 + 3.
- Back-to-back: din 0xAABBCCDD then 0x01020304 presented continuously, out_ready=1 → 8 consecutive slices DD,CC,BB,AA,04,03,02,01 with no gap; in_ready high only on the last-slice cycle.
- Zero skip (macro defined): din 0x000000A5 → one slice 0xA5 with out_last. din 0x00010000 → 0x00, 0x00, 0x01, last on 0x01. din 0 → one slice 0x00 with out_last.
- Reset mid-word: rst asserted after slice 1 of 0x12345678 → out_valid drops asynchronously. The next word 0xCAFEF00D starts at 0x0D.
